// File: rtl/ecall_rx.sv
// ecall_rx: captures the words the core emits on its ecall pins, buffers
// them in a first-word-fall-through FIFO for a valid/ready consumer, counts
// words lost to overflow, and flags halt/done once the exit word has been
// seen and the buffered words have been drained.
module ecall_rx #(
    parameter int          DEPTH     = 8,
    parameter int          ADDR_W    = 3,
    parameter logic [31:0] HALT_CODE = 32'h0000_000A
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ecall_ready,
    input  logic [31:0]       i_ecall_data,
    output logic              o_valid,
    output logic [31:0]       o_data,
    input  logic              i_ready,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_overflow,
    input  logic              i_clr_ovf,
    output logic [15:0]       o_drop_cnt,
    output logic              o_halted,
    output logic              o_done
);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] COUNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0] COUNT_ZERO = '0;

    state_t            state_reg;
    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_next;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              valid_reg;
    logic [31:0]       data_reg;
    logic [31:0]       data_next;
    logic              ovf_reg;
    logic [15:0]       drop_cnt_reg;
    logic              halted_reg;
    logic              done_reg;

    logic pop;
    logic push_req;
    logic push;
    logic drop;
    logic full;
    logic is_halt;
    logic last_leaving;

    // Handshake qualifiers and next head word for the registered output stage
    always_comb begin
        full         = (count_reg == COUNT_FULL);
        pop          = valid_reg & i_ready;
        is_halt      = i_ecall_ready & (i_ecall_data == HALT_CODE);
        push_req     = i_ecall_ready & (state_reg == S_RUN) & (i_ecall_data != HALT_CODE);
        push         = push_req & (~full | pop);
        drop         = push_req & full & ~pop;
        rd_ptr_next  = rd_ptr_reg + ADDR_W'(pop);
        last_leaving = (count_reg == COUNT_ZERO) | ((count_reg == COUNT_ONE) & pop);
        count_next   = count_reg;
        if (push & ~pop)
            count_next = count_reg + COUNT_ONE;
        else if (pop & ~push)
            count_next = count_reg - COUNT_ONE;
        // The head comes from the incoming word when the FIFO is (or becomes)
        // empty this cycle, otherwise from storage; held when nothing is left.
        data_next = data_reg;
        if (count_next != COUNT_ZERO) begin
            if (last_leaving)
                data_next = i_ecall_data;
            else
                data_next = mem[rd_ptr_next];
        end
    end

    // Storage array: written on accepted pushes only, never reset
    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr_reg] <= i_ecall_data;
    end

    // Pointers, occupancy and registered head word
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            valid_reg  <= 1'b0;
            data_reg   <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            valid_reg  <= (count_next != COUNT_ZERO);
            data_reg   <= data_next;
        end
    end

    // Overflow flag and saturating drop counter; a clear beats a drop
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (i_clr_ovf) begin
            ovf_reg      <= 1'b0;
            drop_cnt_reg <= '0;
        end else if (drop) begin
            ovf_reg <= 1'b1;
            if (drop_cnt_reg != 16'hFFFF)
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    // Run / drain / done sequencing with sticky halted and done flags
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= S_RUN;
            halted_reg <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_RUN: begin
                    if (is_halt) begin
                        state_reg  <= S_DRAIN;
                        halted_reg <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (last_leaving) begin
                        state_reg <= S_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                S_DONE: state_reg <= S_DONE;
                default: state_reg <= S_RUN;
            endcase
        end
    end

    assign o_valid    = valid_reg;
    assign o_data     = data_reg;
    assign o_count    = count_reg;
    assign o_full     = full;
    assign o_overflow = ovf_reg;
    assign o_drop_cnt = drop_cnt_reg;
    assign o_halted   = halted_reg;
    assign o_done     = done_reg;

endmodule
